// File: rtl/spi_dac_pkg.sv
// Shared types and helpers for the DAC7311-class SPI output path.
package spi_dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    END,
    GAP
  } state_t;

  localparam int unsigned FRAME_BITS = 16;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // DAC frame: power-down bits, 8-bit sample as D11..D4, D3..D0 zero, two don't-care bits.
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [1:0] pd,
                                                       input logic [7:0] sample);
    return {pd, sample, 4'b0000, 2'b00};
  endfunction

endpackage

// File: rtl/spi_output_controller_dac_tick.sv
// Half-period strobe generator: one-cycle tick every CLK_DIV clocks while enabled.
module spi_half_period_tick #(
  parameter int unsigned CLK_DIV = 26
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running modulo-CLK_DIV counter, held at zero while disabled.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/spi_output_controller_dac.sv
// SPI transmitter streaming 8-bit samples to a 16-bit-frame serial DAC, with a
// one-deep holding register so the next sample can be accepted mid-frame.
module spi_output_controller_dac #(
  parameter int unsigned CLK_DIV       = 26,
  parameter int unsigned CS_HIGH_TICKS = 2,
  parameter int unsigned FRAME_BITS    = 16
) (
  input  logic       clock_50Mhz,
  input  logic       reset_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [1:0] pd_mode,
  output logic       busy,
  output logic       frame_done,
  output logic       dac_sclk,
  output logic       dac_sync_n,
  output logic       dac_mosi
);

  import spi_dac_pkg::*;

  localparam int unsigned IW = $clog2(FRAME_BITS);
  localparam int unsigned GW = (CS_HIGH_TICKS > 1) ? $clog2(CS_HIGH_TICKS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_HIGH_TICKS - 1);

  state_t                state, state_nxt;
  logic [7:0]            hold;
  logic                  hold_full;
  logic                  accept;
  logic                  frame_load;
  logic                  tick;
  logic [FRAME_BITS-1:0] shift_reg, shift_nxt;
  logic [IW-1:0]         bit_idx, idx_nxt;
  logic [GW-1:0]         gap_cnt, gap_nxt;
  logic                  sync_nxt, sclk_nxt, mosi_nxt, done_nxt;

  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;
  assign busy         = (state != IDLE);

  spi_half_period_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock_50Mhz (clock_50Mhz),
    .reset_n     (reset_n),
    .enable      (state != IDLE),
    .tick        (tick)
  );

  // Holding register: filled on handshake, drained when IDLE loads a frame.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) begin
        hold <= sample_in;
      end
      hold_full <= (hold_full && !frame_load) || accept;
    end
  end

  // State and pin registers.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      dac_sync_n <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_mosi   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_idx    <= idx_nxt;
      gap_cnt    <= gap_nxt;
      dac_sync_n <= sync_nxt;
      dac_sclk   <= sclk_nxt;
      dac_mosi   <= mosi_nxt;
      frame_done <= done_nxt;
    end
  end

  // Next-state and next-pin logic; MOSI only moves on rising SCLK (or frame load).
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_reg;
    idx_nxt    = bit_idx;
    gap_nxt    = gap_cnt;
    sync_nxt   = dac_sync_n;
    sclk_nxt   = dac_sclk;
    mosi_nxt   = dac_mosi;
    done_nxt   = 1'b0;
    frame_load = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          frame_load = 1'b1;
          shift_nxt  = pack_frame(pd_mode, hold);
          sync_nxt   = 1'b0;
          mosi_nxt   = shift_nxt[FRAME_BITS-1];
          idx_nxt    = IDX_LAST;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_nxt  = 1'b0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_nxt = !dac_sclk;
          if (!dac_sclk) begin
            if (bit_idx == '0) begin
              state_nxt = END;
            end else begin
              idx_nxt  = bit_idx - IW'(1);
              mosi_nxt = shift_reg[idx_nxt];
            end
          end
        end
      end
      END: begin
        if (tick) begin
          sync_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
          done_nxt  = 1'b1;
          gap_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt == GAP_LAST) begin
            state_nxt = IDLE;
          end else begin
            gap_nxt = gap_cnt + GW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
